aws_axi_sel_ctrl: RTL and testbench
===================================

Name: aws_axi_sel_ctrl

Overview:
Sequences the select line of the record/replay AXI bus selectors so the selector only switches when the target bus is quiescent. It monitors handshakes on the selected (output) side of the selector and counts outstanding write and read bursts. On a CSR-requested change it holds off new AW/AR issue, drains in-flight traffic, flips sel, then releases. It sits between the CSR block and the selector's sel input; the integrator gates source awvalid/arvalid (and the returned awready/arready) with ~hold.

Parameters:
CNT_W, 8, width of the outstanding-burst counters (write, read); the W balance counter is CNT_W+1 bits, signed
TIMEOUT, 1024, DRAIN cycles before the timeout flag sets; 0 disables timeout
SEL_RST, 0, value of sel after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
sel_req  in  1  requested selection from CSR (level)
clr_err  in  1  clears the timeout and proto_err flags
awvalid awready wvalid wready wlast bvalid bready arvalid arready rvalid rready rlast  in  1 each  handshake signals observed on the selector's output bus
sel  out  1  registered select to the selector
hold  out  1  block new AW/AR from the sources
busy  out  1  state != STABLE
done  out  1  one-cycle pulse when a switch completes
timeout  out  1  sticky flag: drain exceeded TIMEOUT cycles
proto_err  out  1  sticky flag: counter underflow or saturation
wr_out  out  CNT_W  outstanding writes (AW accepted, B not yet accepted)
rd_out  out  CNT_W  outstanding reads (AR accepted, last R beat not yet accepted)

Behaviour:
- Reset (async): state=STABLE, sel=SEL_RST, hold=0, busy=0, done=0, timeout=0, proto_err=0, all counters=0, target=SEL_RST, drain timer=0.
- Handshake definitions: aw_hs=awvalid&awready; b_hs=bvalid&bready; ar_hs=arvalid&arready; wl_hs=wvalid&wready&wlast; rl_hs=rvalid&rready&rlast.
- Counters update every cycle in every state:
  - wr_out += aw_hs − b_hs.
  - rd_out += ar_hs − rl_hs.
  - wbal += aw_hs − wl_hs. wbal is signed, and negative is legal because W may lead AW.
  - A simultaneous increment and decrement nets to no change.
  - A decrement at 0 on wr_out/rd_out holds the value at 0 and sets proto_err.
  - An increment at max holds the value at max and sets proto_err. wbal saturates the same way at its signed limits.
- quiet = (wr_out==0) & (rd_out==0) & (wbal==0) & no aw_hs, ar_hs, w beat, b_hs or r beat in the current cycle.
- STABLE:
  - hold=0.
  - If sel_req != sel: capture target=sel_req, go to DRAIN, hold=1 from the next cycle. The hold register is updated at the same edge as state.
- DRAIN:
  - hold=1; the drain timer increments, saturating.
  - If sel_req == sel (request withdrawn): go to STABLE, hold=0, no done pulse, timer cleared.
  - Else if quiet: go to SWITCH.
  - If TIMEOUT!=0 and the timer reaches TIMEOUT: set timeout and keep draining. The switch is never forced.
- SWITCH (1 cycle):
  - sel<=target registered on entry, hold stays 1.
  - Next state STABLE, with done=1 for that one cycle and timer cleared.
- Latency: sel_req change sampled at edge 0 → hold=1 after edge 0. If already quiet, DRAIN→SWITCH at edge 1, sel flips at edge 1, hold=0 and done=1 after edge 2.
- A handshake completing in the cycle the request is sampled, before hold is visible, is counted and must drain.
- sel_req changes during SWITCH are ignored and re-evaluated in STABLE on the next cycle.
- clr_err clears timeout and proto_err. A set condition in the same cycle wins.
- Reset mid-drain returns to the reset state. The bus must be reset together with this block.

Test Plan:
1. Idle bus, sel=0, sel_req 0→1 at edge 0 → hold high after edge 0, sel=1 after edge 1, done pulse and hold low after edge 2, busy high exactly 2 cycles.
2. Two AWs (len 3) accepted, W bursts complete, B responses withheld 20 cycles, then sel_req toggles → wr_out=2, sel stays put until the second B is accepted, sel flips 1 edge later, wr_out=0.
3. AR accepted with 4 R beats outstanding, sel_req toggles then returns to the old value after 3 cycles → state back to STABLE, hold=0, no done, sel unchanged.
4. TIMEOUT=16, one B never returned, sel_req toggled → timeout=1 after 16 DRAIN cycles, sel unchanged. Then return the B → switch completes; clr_err clears timeout.
5. bvalid&bready with wr_out=0 → proto_err=1, wr_out stays 0. Then aw_hs and b_hs in the same cycle with wr_out=1 → wr_out stays 1.
6. W burst with wlast accepted before its AW (wbal=−1), request pending → no switch until the AW is accepted and its B returns; async reset asserted mid-DRAIN → sel=SEL_RST, hold=0, counters 0 immediately.

Source files
------------

// File: rtl/aws_axi_sel_ctrl.sv
// Select-line sequencer for the record/replay AXI bus selectors: blocks new AW/AR,
// drains outstanding bursts on the selected bus, then flips sel while the bus is idle.
module aws_axi_sel_ctrl #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024,
    parameter bit SEL_RST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel_req,
    input  logic             clr_err,
    input  logic             awvalid,
    input  logic             awready,
    input  logic             wvalid,
    input  logic             wready,
    input  logic             wlast,
    input  logic             bvalid,
    input  logic             bready,
    input  logic             arvalid,
    input  logic             arready,
    input  logic             rvalid,
    input  logic             rready,
    input  logic             rlast,
    output logic             sel,
    output logic             hold,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             proto_err,
    output logic [CNT_W-1:0] wr_out,
    output logic [CNT_W-1:0] rd_out
);

    typedef enum logic [1:0] {STABLE, DRAIN, SWITCH} state_t;

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic signed [CNT_W:0] WBAL_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic signed [CNT_W:0] WBAL_MIN = {1'b1, {CNT_W{1'b0}}};

    // Returns {error, next}; an overflow or underflow holds the count.
    function automatic logic [CNT_W:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        logic             err;
        nxt = cnt;
        err = 1'b0;
        if (inc && !dec) begin
            if (&cnt) err = 1'b1;
            else      nxt = cnt + 1'b1;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           nxt = cnt - 1'b1;
        end
        return {err, nxt};
    endfunction

    // Signed W balance: negative means W data led its AW.
    function automatic logic [CNT_W+1:0] bal_step(input logic signed [CNT_W:0] bal,
                                                  input logic inc, input logic dec);
        logic signed [CNT_W:0] nxt;
        logic                  err;
        nxt = bal;
        err = 1'b0;
        if (inc && !dec) begin
            if (bal == WBAL_MAX) err = 1'b1;
            else                 nxt = bal + 1'sb1;
        end else if (dec && !inc) begin
            if (bal == WBAL_MIN) err = 1'b1;
            else                 nxt = bal - 1'sb1;
        end
        return {err, nxt};
    endfunction

    state_t                state, state_nxt;
    logic                  target;
    logic signed [CNT_W:0] wbal, wbal_nxt;
    logic [CNT_W-1:0]      wr_nxt, rd_nxt;
    logic                  wr_err, rd_err, wb_err;
    logic [TMR_W-1:0]      tmr, tmr_inc;
    logic                  aw_hs, b_hs, ar_hs, w_hs, r_hs, wl_hs, rl_hs;
    logic                  quiet, to_hit;

    always_comb begin
        aw_hs = awvalid & awready;
        b_hs  = bvalid & bready;
        ar_hs = arvalid & arready;
        w_hs  = wvalid & wready;
        r_hs  = rvalid & rready;
        wl_hs = w_hs & wlast;
        rl_hs = r_hs & rlast;
        {wr_err, wr_nxt}   = cnt_step(wr_out, aw_hs, b_hs);
        {rd_err, rd_nxt}   = cnt_step(rd_out, ar_hs, rl_hs);
        {wb_err, wbal_nxt} = bal_step(wbal, aw_hs, wl_hs);
        quiet   = (wr_out == '0) && (rd_out == '0) && (wbal == '0) &&
                  !(aw_hs || ar_hs || w_hs || b_hs || r_hs);
        tmr_inc = (&tmr) ? tmr : tmr + 1'b1;
        to_hit  = (TIMEOUT != 0) && (state == DRAIN) && (tmr_inc >= TMR_W'(TIMEOUT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= STABLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STABLE: if (sel_req != sel) state_nxt = DRAIN;
            DRAIN: begin
                if (sel_req == sel) state_nxt = STABLE;
                else if (quiet)     state_nxt = SWITCH;
            end
            SWITCH:  state_nxt = STABLE;
            default: state_nxt = STABLE;
        endcase
    end

    always_comb begin
        hold = (state != STABLE);
        busy = (state != STABLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel       <= SEL_RST;
            target    <= SEL_RST;
            done      <= 1'b0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            wr_out    <= '0;
            rd_out    <= '0;
            wbal      <= '0;
            tmr       <= '0;
        end else begin
            if (state == STABLE && state_nxt == DRAIN) target <= sel_req;
            if (state == DRAIN && state_nxt == SWITCH) sel <= target;
            done      <= (state == SWITCH);
            tmr       <= (state == DRAIN && state_nxt == DRAIN) ? tmr_inc : '0;
            timeout   <= to_hit | (timeout & ~clr_err);
            proto_err <= wr_err | rd_err | wb_err | (proto_err & ~clr_err);
            wr_out    <= wr_nxt;
            rd_out    <= rd_nxt;
            wbal      <= wbal_nxt;
        end
    end

endmodule

// File: tb/tb_aws_axi_sel_ctrl.sv
// Directed bench for aws_axi_sel_ctrl: idle switch, drain on outstanding B/R,
// request withdrawal, drain timeout, counter saturation, W-before-AW and async reset.
module tb_aws_axi_sel_ctrl;

    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst, sel_req, clr_err;
    logic awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic arvalid, arready, rvalid, rready, rlast;
    logic sel, hold, busy, done, timeout, proto_err;
    logic [CNT_W-1:0] wr_out, rd_out;

    int n_cmp = 0;
    int n_err = 0;

    aws_axi_sel_ctrl #(.CNT_W(CNT_W), .TIMEOUT(16), .SEL_RST(1'b0)) dut (
        .clk(clk), .rst(rst), .sel_req(sel_req), .clr_err(clr_err),
        .awvalid(awvalid), .awready(awready), .wvalid(wvalid), .wready(wready),
        .wlast(wlast), .bvalid(bvalid), .bready(bready), .arvalid(arvalid),
        .arready(arready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .sel(sel), .hold(hold), .busy(busy), .done(done), .timeout(timeout),
        .proto_err(proto_err), .wr_out(wr_out), .rd_out(rd_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive valid and ready together so each flag is one completed handshake.
    task automatic bus(input logic aw, input logic w, input logic wl, input logic b,
                       input logic ar, input logic r, input logic rl);
        awvalid = aw; awready = aw;
        wvalid  = w;  wready  = w;  wlast = wl;
        bvalid  = b;  bready  = b;
        arvalid = ar; arready = ar;
        rvalid  = r;  rready  = r;  rlast = rl;
    endtask

    task automatic idle(input int n);
        bus(0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; sel_req = 1'b0; clr_err = 1'b0;
        bus(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_hold", hold, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_wr", wr_out, 0);
        chk("rst_rd", rd_out, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // 1: idle bus switch 0 -> 1
        sel_req = 1'b1;
        tick();
        chk("t1_hold_e0", hold, 1);
        chk("t1_sel_e0", sel, 0);
        chk("t1_busy_e0", busy, 1);
        tick();
        chk("t1_sel_e1", sel, 1);
        chk("t1_hold_e1", hold, 1);
        chk("t1_done_e1", done, 0);
        tick();
        chk("t1_done_e2", done, 1);
        chk("t1_hold_e2", hold, 0);
        chk("t1_busy_e2", busy, 0);
        tick();
        chk("t1_done_e3", done, 0);

        // 2: two writes with B withheld
        bus(1, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        for (int i = 1; i <= 8; i++) begin
            bus(0, 1, (i % 4) == 0, 0, 0, 0, 0);
            tick();
        end
        idle(20);
        chk("t2_wr_two", wr_out, 2);
        chk("t2_hold_pre", hold, 0);
        sel_req = 1'b0;
        tick();
        chk("t2_hold_drain", hold, 1);
        idle(5);
        chk("t2_sel_wait", sel, 1);
        bus(0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("t2_wr_one", wr_out, 1);
        idle(1);
        bus(0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("t2_wr_zero", wr_out, 0);
        chk("t2_sel_b2", sel, 1);
        idle(1);
        chk("t2_sel_flip", sel, 0);
        tick();
        chk("t2_done", done, 1);
        chk("t2_hold_end", hold, 0);
        chk("t2_timeout", timeout, 0);

        // 3: read outstanding, request withdrawn
        bus(0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("t3_rd_one", rd_out, 1);
        bus(0, 0, 0, 0, 0, 0, 0);
        sel_req = 1'b1;
        tick();
        chk("t3_hold_drain", hold, 1);
        tick(); tick();
        sel_req = 1'b0;
        tick();
        chk("t3_hold_back", hold, 0);
        chk("t3_busy_back", busy, 0);
        chk("t3_sel_same", sel, 0);
        chk("t3_done_none", done, 0);
        tick();
        chk("t3_done_none2", done, 0);
        for (int i = 1; i <= 4; i++) begin
            bus(0, 0, 0, 0, 0, 1, i == 4);
            tick();
        end
        chk("t3_rd_zero", rd_out, 0);
        idle(1);

        // 4: drain timeout after 16 cycles
        bus(1, 1, 1, 0, 0, 0, 0);
        tick();
        chk("t4_wr_one", wr_out, 1);
        bus(0, 0, 0, 0, 0, 0, 0);
        sel_req = 1'b1;
        tick();
        repeat (15) tick();
        chk("t4_to_15", timeout, 0);
        tick();
        chk("t4_to_16", timeout, 1);
        chk("t4_sel_held", sel, 0);
        chk("t4_hold", hold, 1);
        bus(0, 0, 0, 1, 0, 0, 0);
        tick();
        idle(1);
        chk("t4_sel_flip", sel, 1);
        tick();
        chk("t4_done", done, 1);
        chk("t4_to_sticky", timeout, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t4_to_clr", timeout, 0);

        // 5: counter underflow / simultaneous / saturation
        bus(0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("t5_wr_under", wr_out, 0);
        chk("t5_proto_under", proto_err, 1);
        bus(0, 0, 0, 0, 0, 0, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_proto_clr", proto_err, 0);
        bus(1, 0, 0, 0, 0, 0, 0);
        tick();
        bus(1, 0, 0, 1, 0, 0, 0);
        tick();
        chk("t5_wr_net", wr_out, 1);
        chk("t5_proto_net", proto_err, 0);
        bus(0, 1, 1, 1, 0, 0, 0);
        tick();
        bus(0, 1, 1, 0, 0, 0, 0);
        tick();
        chk("t5_wr_back", wr_out, 0);
        bus(0, 0, 0, 0, 1, 0, 0);
        repeat (255) tick();
        chk("t5_rd_max", rd_out, 255);
        chk("t5_proto_max", proto_err, 0);
        tick();
        chk("t5_rd_sat", rd_out, 255);
        chk("t5_proto_sat", proto_err, 1);
        bus(0, 0, 0, 0, 0, 1, 1);
        repeat (255) tick();
        chk("t5_rd_drained", rd_out, 0);
        bus(0, 0, 0, 0, 0, 0, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_proto_clr2", proto_err, 0);
        chk("t5_sel_stable", sel, 1);

        // 6a: async reset mid-drain
        bus(1, 0, 0, 0, 1, 0, 0);
        tick();
        bus(0, 0, 0, 0, 0, 0, 0);
        sel_req = 1'b0;
        tick();
        tick();
        chk("t6_hold_pre", hold, 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_sel", sel, 0);
        chk("t6_rst_hold", hold, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_wr", wr_out, 0);
        chk("t6_rst_rd", rd_out, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_post_busy", busy, 0);

        // 6b: W leads AW
        bus(0, 1, 0, 0, 0, 0, 0);
        tick();
        bus(0, 1, 1, 0, 0, 0, 0);
        tick();
        bus(0, 0, 0, 0, 0, 0, 0);
        sel_req = 1'b1;
        tick();
        idle(3);
        chk("t6_wbal_wait", sel, 0);
        chk("t6_wbal_hold", hold, 1);
        bus(1, 0, 0, 0, 0, 0, 0);
        tick();
        chk("t6_wr_aw", wr_out, 1);
        idle(2);
        chk("t6_sel_b_wait", sel, 0);
        bus(0, 0, 0, 1, 0, 0, 0);
        tick();
        chk("t6_wr_b", wr_out, 0);
        chk("t6_sel_b_edge", sel, 0);
        idle(1);
        chk("t6_sel_flip", sel, 1);
        tick();
        chk("t6_done", done, 1);
        chk("t6_hold_end", hold, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
